serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the team's existing 1-bit full adder (`adder`: inputs `a`, `b`, `c`; outputs `result`, `carry_out`). It accepts two parallel operands plus a carry-in, feeds one bit pair per clock into the full adder LSB-first, and registers the carry between cycles. It collects result bits into a parallel sum. It sits directly around the full-adder stage: it is the sequencer that feeds the stage and consumes its outputs. It reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 8, operand and sum width in bits; legal range 1..32.
- `clk`  input  1  rising-edge clock; sole clock.
- `rst_n`  input  1  reset, synchronous, active-low.
- `start`  input  1  request; sampled on `clk` rising edge; accepted only in IDLE.
- `a`  input  WIDTH  operand A; sampled on the accepting edge only.
- `b`  input  WIDTH  operand B; sampled on the accepting edge only.
- `cin`  input  1  carry-in; sampled on the accepting edge only.
- `busy`  output  1  high while in SHIFT.
- `done`  output  1  one-cycle pulse; high while in DONE.
- `sum`  output  WIDTH  registered result; low WIDTH bits of a+b+cin.
- `cout`  output  1  registered carry-out; bit WIDTH of a+b+cin.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:**
  - If `start`=1, load `a` and `b` into shift registers `a_sr` and `b_sr`, load `cin` into carry flop `c_q`, and clear bit counter `cnt`. Next state is SHIFT.
  - Otherwise, remain in IDLE.
- **SHIFT:**
  - Each cycle, the full-adder instance is driven with `a_sr[0]`, `b_sr[0]` and `c_q`.
  - On the edge:
    - `a_sr` and `b_sr` shift right by 1.
    - `result` shifts into the MSB of internal register `s_sr` (shift right).
    - `c_q` <= `carry_out`.
    - `cnt` <= `cnt`+1.
  - On the edge where `cnt`=WIDTH-1:
    - Copy the completed `s_sr` (including this edge's bit) to `sum`.
    - Copy `carry_out` to `cout`.
    - Next state is DONE.
- **DONE:**
  - `done`=1 for exactly one cycle.
  - Next state is always IDLE.
  - `start` is ignored in DONE.
- `start` in SHIFT or DONE is ignored. In-flight operands are unaffected and no request is queued.
- `sum` and `cout` change only on the edge entering DONE. They hold their value through IDLE and the whole next operation until that operation completes.
- `cnt` width is clog2(WIDTH+1). The arithmetic is exact modulo 2^(WIDTH+1) across {`cout`, `sum`}.
- With WIDTH=1, SHIFT lasts one cycle.
- The full adder must be instantiated, not re-expressed inline.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - `a_sr`, `b_sr`, `s_sr`, `c_q` and `cnt` are cleared.
  - Reset takes priority over `start`.
- Reset mid-SHIFT aborts the operation. No `done` pulse is produced, and `sum`/`cout` read 0 afterwards.
- The accepting edge is E0. `busy`=1 in the cycles following E0 through E(WIDTH-1), i.e. for WIDTH cycles.
- `done`=1 in the cycle following E(WIDTH). `sum`/`cout` are valid from that same cycle.
- Latency from `start` acceptance to `done` is WIDTH+1 cycles. The minimum interval between accepted starts is WIDTH+2 cycles: the next accept is at E(WIDTH+2) at the earliest.
- `busy` and `done` are never high together. Both are registered outputs (state decode), with no combinational path from inputs.

## Test plan
- **Basic add.** WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0 → `busy` high for 8 cycles, `done` pulses 9 cycles after accept, `sum`=0x96, `cout`=0.
- **Carry ripple.**
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1.
  - `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Ignored start.** Accept 0x10+0x20, then hold `start`=1 with `a`=0xAA, `b`=0x55 through SHIFT and DONE → first result `sum`=0x30, `cout`=0. The second operation is accepted at the first IDLE edge and yields `sum`=0xFF, `cout`=0, with its `done` exactly WIDTH+2 edges after the first.
- **Reset mid-operation.** Assert `rst_n`=0 at the 4th SHIFT edge of 0x80+0x80 → `busy`=0 next cycle, no `done` pulse, `sum`=0, `cout`=0. A fresh 0x01+0x01 then yields `sum`=0x02.
- **Exhaustive at WIDTH=4.** All 512 combinations of `a`, `b` and `cin` back-to-back → {`cout`,`sum`} equals `a`+`b`+`cin` each time, one `done` pulse per operation, and `sum` stable between pulses.
- **WIDTH=1.** `a`=1, `b`=1, `cin`=1 → `busy` 1 cycle, `done` 2 cycles after accept, `sum`=1, `cout`=1.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder: bit-serial WIDTH-bit adder around a 1-bit full-adder stage.
//
// The operands are loaded in parallel on an accepted start. One bit pair per
// clock goes through the full adder, LSB first, and the carry is held in a
// flop between cycles. Result bits are collected into a parallel sum, and
// completion is flagged with a single-cycle done pulse.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request, accepted only in IDLE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while serial addition is in progress
//   done   out  one-cycle completion pulse
//   sum    out  low WIDTH bits of a+b+cin, held until the next completion
//   cout   out  bit WIDTH of a+b+cin, held until the next completion
//
// Also contains `adder`, the 1-bit full-adder stage that serial_adder drives.
// ---------------------------------------------------------------------------

// 1-bit full adder: result = a^b^c, carry_out = majority(a, b, c).
module adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic result,
    output logic carry_out
);

    assign result    = a ^ b ^ c;
    assign carry_out = (a & b) | (c & (a ^ b));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter must be able to hold WIDTH.
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // The counter value seen on the last shift edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_q;
    logic [CNT_W-1:0] cnt;

    logic             fa_result;
    logic             fa_carry;
    logic [WIDTH-1:0] s_next;

    // The single full-adder stage sees the current LSBs and the held carry.
    adder u_fa (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .c         (c_q),
        .result    (fa_result),
        .carry_out (fa_carry)
    );

    // Sum register after this edge's bit is shifted in at the MSB.
    // When WIDTH is 1 there are no older bits to keep.
    generate
        if (WIDTH == 1) begin : g_snext_w1
            assign s_next = fa_result;
        end else begin : g_snext_wn
            assign s_next = {fa_result, s_sr[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer: state, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c_q   <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    c_q  <= fa_carry;
                    cnt  <= cnt + CNT_W'(1);
                    // On the last bit, publish the sum including this edge's bit.
                    if (cnt == CNT_LAST) begin
                        sum   <= s_next;
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder: self-checking bench for serial_adder.
//
// Three instances share one clock and reset: WIDTH=8 for the directed
// vectors and sequences, WIDTH=4 for the exhaustive sweep, and WIDTH=1 for
// the single-bit case. Inputs are driven and outputs sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int total;
    int bad;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One WIDTH=8 operation; the DUT must be idle at the call. lat counts
    // cycles after the accepting edge up to the done cycle (-1 on timeout).
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output logic [7:0] osum, output logic ocout,
                        output int lat, output int busy_n, output int overlap);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        lat = -1; busy_n = 0; overlap = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) busy_n++;
            if (busy8 && done8) overlap = 1;
            if (done8) begin
                lat = k;
                break;
            end
        end
        osum  = sum8;
        ocout = cout8;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    initial begin
        vec_t       vt[6];
        logic [7:0] s;
        logic       c;
        int         lat, bn, ov;

        total = 0; bad = 0;
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst_n = 1'b0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_sum8",  32'(sum8), 0);
        chk("rst_cout8", 32'(cout8), 0);
        chk("rst_busy4", 32'(busy4), 0);
        chk("rst_sum1",  32'(sum1), 0);
        rst_n = 1'b1;

        // Directed vectors at WIDTH=8.
        for (int i = 0; i < 6; i++) begin
            run8(vt[i].a, vt[i].b, vt[i].cin, s, c, lat, bn, ov);
            chk($sformatf("vec%0d_sum", i),  32'(s), 32'(vt[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vt[i].cout));
            chk($sformatf("vec%0d_lat", i),  32'(lat), 9);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bn), 8);
            chk($sformatf("vec%0d_overlap", i), 32'(ov), 0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_fall", i), 32'(done8), 0);
        end

        // start held through SHIFT and DONE: the second request waits for IDLE.
        begin
            int         d1, d2;
            logic [7:0] s1, s2;
            logic       c1, c2;
            d1 = -1; d2 = -1; s1 = 0; s2 = 0; c1 = 0; c2 = 0;
            @(negedge clk);
            a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1'b1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                a8 = 8'hAA; b8 = 8'h55;
                if (done8 && d1 < 0) begin
                    d1 = k; s1 = sum8; c1 = cout8;
                end else if (done8) begin
                    d2 = k; s2 = sum8; c2 = cout8;
                    start8 = 1'b0;
                    break;
                end
            end
            start8 = 1'b0;
            chk("hold_first_sum",  32'(s1), 32'h30);
            chk("hold_first_cout", 32'(c1), 0);
            chk("hold_first_lat",  32'(d1), 9);
            chk("hold_second_sum", 32'(s2), 32'hFF);
            chk("hold_second_cout", 32'(c2), 0);
            chk("hold_done_spacing", 32'(d2 - d1), 10);
            @(negedge clk);
            @(negedge clk);
            chk("hold_no_third_accept", 32'(busy8), 0);
        end

        // Reset asserted so that the 4th shift edge samples it.
        begin
            int pulses;
            @(negedge clk);
            a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk("midrst_busy", 32'(busy8), 0);
            chk("midrst_done", 32'(done8), 0);
            chk("midrst_sum",  32'(sum8), 0);
            chk("midrst_cout", 32'(cout8), 0);
            rst_n = 1'b1;
            pulses = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done8) pulses++;
            end
            chk("midrst_no_done", 32'(pulses), 0);
            run8(8'h01, 8'h01, 1'b0, s, c, lat, bn, ov);
            chk("after_rst_sum", 32'(s), 32'h02);
            chk("after_rst_cout", 32'(c), 0);
            chk("after_rst_lat", 32'(lat), 9);
        end

        // WIDTH=1: one shift cycle, done in the second cycle.
        begin
            logic [1:0] v1 [2];
            logic [1:0] e1 [2];
            logic       ci1 [2];
            v1[0] = 2'b11; ci1[0] = 1'b1; e1[0] = 2'b11;
            v1[1] = 2'b01; ci1[1] = 1'b0; e1[1] = 2'b01;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                a1 = v1[i][0]; b1 = v1[i][1]; cin1 = ci1[i]; start1 = 1'b1;
                lat = -1; bn = 0;
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    start1 = 1'b0;
                    if (busy1) bn++;
                    if (done1) begin
                        lat = k;
                        break;
                    end
                end
                chk($sformatf("w1_%0d_result", i), 32'({cout1, sum1}), 32'(e1[i]));
                chk($sformatf("w1_%0d_lat", i), 32'(lat), 2);
                chk($sformatf("w1_%0d_busy_cycles", i), 32'(bn), 1);
            end
        end

        // Exhaustive back-to-back sweep at WIDTH=4.
        begin
            logic [3:0] ref_sum;
            logic [8:0] v;
            int         accepted, seen, extra, unstable, errs_before;
            ref_sum = sum4;
            errs_before = bad;
            @(negedge clk);
            for (int i = 0; i < 512; i++) begin
                v = 9'(i);
                a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; start4 = 1'b1;
                accepted = 0; extra = 0; unstable = 0; seen = 0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (done4) extra = 1;
                    if (sum4 !== ref_sum) unstable = 1;
                    if (busy4) begin
                        accepted = 1;
                        break;
                    end
                end
                start4 = 1'b0;
                for (int k = 0; k < 10 && accepted == 1; k++) begin
                    @(negedge clk);
                    if (done4) begin
                        seen = 1;
                        break;
                    end
                    if (sum4 !== ref_sum) unstable = 1;
                end
                if (bad == errs_before || i < 4) begin
                    chk($sformatf("w4_%0d_accept", i), 32'(accepted), 1);
                    chk($sformatf("w4_%0d_done", i), 32'(seen), 1);
                    chk($sformatf("w4_%0d_result", i), 32'({cout4, sum4}),
                        32'(v[3:0]) + 32'(v[7:4]) + 32'(v[8]));
                    chk($sformatf("w4_%0d_extra_done", i), 32'(extra), 0);
                    chk($sformatf("w4_%0d_sum_stable", i), 32'(unstable), 0);
                end
                ref_sum = sum4;
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
